// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver:
//   - baud_select encoding constants
//   - baud rate lookup and divisor function (CLK_HZ / (OVERSAMPLE * baud), rounded)
//   - transmitter FSM state type
//   - frame-length constants
// -----------------------------------------------------------------------------
package uart_pkg;

  // baud_select encoding
  localparam logic [2:0] BAUD_300    = 3'b000;
  localparam logic [2:0] BAUD_1200   = 3'b001;
  localparam logic [2:0] BAUD_4800   = 3'b010;
  localparam logic [2:0] BAUD_9600   = 3'b011;
  localparam logic [2:0] BAUD_19200  = 3'b100;
  localparam logic [2:0] BAUD_38400  = 3'b101;
  localparam logic [2:0] BAUD_57600  = 3'b110;
  localparam logic [2:0] BAUD_115200 = 3'b111;

  // Frame shape
  localparam int DATA_BITS     = 8;
  localparam int TICKS_PER_BIT = 16;

  // Divisor counter width; the slowest rate at 50 MHz needs 10417 (14 bits).
  localparam int DIV_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic int baud_rate(input logic [2:0] sel);
    int rate;
    case (sel)
      BAUD_300:    rate = 300;
      BAUD_1200:   rate = 1200;
      BAUD_4800:   rate = 4800;
      BAUD_9600:   rate = 9600;
      BAUD_19200:  rate = 19200;
      BAUD_38400:  rate = 38400;
      BAUD_57600:  rate = 57600;
      default:     rate = 115200;
    endcase
    return rate;
  endfunction

  // Clocks per sample tick, rounded to nearest (half rounds up).
  function automatic int baud_divisor(input int clk_hz, input int oversample,
                                      input logic [2:0] sel);
    int denom;
    denom = oversample * baud_rate(sel);
    return (clk_hz + denom / 2) / denom;
  endfunction

endpackage

// File: rtl/baud_controller.sv
// -----------------------------------------------------------------------------
// baud_controller
// Generates a one-cycle sample_tick every DIV clocks, where DIV is looked up
// from baud_select. Shared unchanged by the transmitter and receiver.
// Ports:
//   clock        system clock
//   reset        synchronous active-high reset
//   clear        restarts the divisor count (tick suppressed this cycle)
//   baud_select  rate select (see uart_pkg encoding)
//   sample_tick  one-cycle pulse when the count reaches DIV-1
// -----------------------------------------------------------------------------
module baud_controller
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVERSAMPLE = TICKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic [2:0] baud_select,
  output logic       sample_tick
);

  logic [DIV_W-1:0] div_table [8];
  logic [DIV_W-1:0] div_last;
  logic [DIV_W-1:0] cnt_reg;

  // Divisor table is fully constant; one entry per baud_select code.
  for (genvar gi = 0; gi < 8; gi++) begin : g_div
    assign div_table[gi] = DIV_W'(baud_divisor(CLK_HZ, OVERSAMPLE, 3'(gi)));
  end

  assign div_last    = div_table[baud_select] - 1'b1;
  assign sample_tick = (cnt_reg == div_last) && !clear;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt_reg <= '0;
    end else if (cnt_reg == div_last) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// Serialises a byte as: start(0), 8 data bits LSB first, even parity, stop(1).
// Each bit lasts OVERSAMPLE sample ticks from baud_controller.
// Ports:
//   clock        system clock
//   reset        synchronous active-high reset
//   baud_select  rate select, latched when a write is accepted
//   Tx_EN        enable; low forces idle and aborts a frame in progress
//   Tx_WR        single-cycle write strobe
//   Tx_DATA      byte to send, latched when a write is accepted
//   TxD          serial output, idles high
//   Tx_BUSY      high while a frame is being sent
//   Tx_DONE      one-cycle pulse after the stop bit completes
// -----------------------------------------------------------------------------
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50_000_000,
  parameter int OVERSAMPLE = TICKS_PER_BIT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_DONE
);

  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  tx_state_t            state_reg,    state_next;
  logic [TICK_W-1:0]    tick_cnt_reg, tick_cnt_next;
  logic [BIT_W-1:0]     bit_cnt_reg,  bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg,    shift_next;
  logic                 parity_reg,   parity_next;
  logic [2:0]           baud_reg,     baud_next;
  logic                 txd_reg,      txd_next;
  logic                 busy_reg,     busy_next;
  logic                 done_reg,     done_next;

  logic accept;
  logic sample_tick;
  logic bit_end;

  // The done cycle is already IDLE, so this also covers back-to-back writes.
  assign accept  = Tx_EN && Tx_WR && (state_reg == IDLE);
  assign bit_end = sample_tick && (tick_cnt_reg == LAST_TICK);

  // Divisor restarts on acceptance so the start bit is a full period long,
  // and runs from the latched rate so mid-frame baud changes are ignored.
  baud_controller #(
    .CLK_HZ     (CLK_HZ),
    .OVERSAMPLE (OVERSAMPLE)
  ) u_baud (
    .clock       (clock),
    .reset       (reset),
    .clear       (!Tx_EN || accept),
    .baud_select (baud_reg),
    .sample_tick (sample_tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg    <= IDLE;
      tick_cnt_reg <= '0;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      parity_reg   <= 1'b0;
      baud_reg     <= '0;
      txd_reg      <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tick_cnt_reg <= tick_cnt_next;
      bit_cnt_reg  <= bit_cnt_next;
      shift_reg    <= shift_next;
      parity_reg   <= parity_next;
      baud_reg     <= baud_next;
      txd_reg      <= txd_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    tick_cnt_next = tick_cnt_reg;
    bit_cnt_next  = bit_cnt_reg;
    shift_next    = shift_reg;
    parity_next   = parity_reg;
    baud_next     = baud_reg;
    done_next     = 1'b0;

    if (!Tx_EN) begin
      // Abort: straight back to idle with no completion pulse.
      state_next    = IDLE;
      tick_cnt_next = '0;
      bit_cnt_next  = '0;
    end else begin
      if (state_reg != IDLE && sample_tick) begin
        tick_cnt_next = bit_end ? '0 : tick_cnt_reg + 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            state_next    = START;
            shift_next    = Tx_DATA;
            parity_next   = ^Tx_DATA;
            baud_next     = baud_select;
            tick_cnt_next = '0;
            bit_cnt_next  = '0;
          end
        end
        START: begin
          if (bit_end) state_next = DATA;
        end
        DATA: begin
          if (bit_end) begin
            shift_next   = {1'b0, shift_reg[DATA_BITS-1:1]};
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == LAST_BIT) state_next = PARITY;
          end
        end
        PARITY: begin
          if (bit_end) state_next = STOP;
        end
        STOP: begin
          if (bit_end) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // Line level and busy follow the next state so they change on the same
  // edge as the FSM (write accepted -> TxD low one cycle later).
  always_comb begin
    txd_next = 1'b1;
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      PARITY:  txd_next = parity_next;
      default: txd_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE);
  end

  assign TxD     = txd_reg;
  assign Tx_BUSY = busy_reg;
  assign Tx_DONE = done_reg;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Stimulus queues an expected frame for each accepted write; an independent
// monitor watches TxD/Tx_BUSY/Tx_DONE cycle by cycle and compares against the
// frame computed from the byte and the bit period of the latched rate.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_transmitter;
  import uart_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         period;  // clocks per bit
    int         cut;     // cycle after start at which the line must be idle again (0 = full frame)
    bit         b2b;     // written in the previous frame's done cycle
  } exp_t;

  logic       clock = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       Tx_EN;
  logic       Tx_WR;
  logic [7:0] Tx_DATA;
  logic       TxD;
  logic       Tx_BUSY;
  logic       Tx_DONE;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  bit   mon_busy = 1'b0;
  int   div_tab [8] = '{10417, 2604, 651, 326, 163, 81, 54, 27};

  always #10 clock = ~clock;

  uart_transmitter #(
    .CLK_HZ     (50_000_000),
    .OVERSAMPLE (16)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .baud_select (baud_select),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .Tx_DATA     (Tx_DATA),
    .TxD         (TxD),
    .Tx_BUSY     (Tx_BUSY),
    .Tx_DONE     (Tx_DONE)
  );

  // ---------------- reference model ----------------
  function automatic int period_of(input logic [2:0] sel);
    return 16 * div_tab[sel];
  endfunction

  // Bit idx of the frame: 0 start, 1..8 data LSB first, 9 even parity, 10 stop.
  function automatic logic frame_bit(input logic [7:0] d, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return d[idx-1];
    if (idx == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    exp_t       cur;
    int         j, bad, gap, bit_i;
    logic [2:0] seen, want, first_bad;
    bit         in_frame, rogue;
    in_frame  = 1'b0;
    rogue     = 1'b0;
    gap       = 1000;
    j         = 0;
    bad       = 0;
    first_bad = '0;
    cur       = '{data: 8'h00, period: 1, cut: 0, b2b: 1'b0};
    forever begin
      @(negedge clock);
      seen = {Tx_DONE, Tx_BUSY, TxD};
      if (!in_frame) begin
        gap++;
        if (rogue) begin
          if (TxD === 1'b1) rogue = 1'b0;
        end else if (TxD === 1'b0) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            rogue = 1'b1;
            $display("FAIL unexpected_start: got TxD low, expected idle (no frame queued)");
          end else begin
            cur      = exp_q.pop_front();
            in_frame = 1'b1;
            j        = 0;
            bad      = 0;
            if (cur.b2b) check($sformatf("b2b_gap_%02h", cur.data), gap, 1);
          end
        end else if (Tx_DONE === 1'b1) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: got Tx_DONE=1 while idle, expected 0");
        end
      end
      if (in_frame) begin
        if (cur.cut > 0 && j == cur.cut) begin
          check($sformatf("abort_%02h", cur.data), 32'(seen), 32'(3'b001));
          $display("[TB] frame %02h aborted after %0d cycles", cur.data, j);
          in_frame = 1'b0;
          gap      = 1000;
        end else if (j == 11 * cur.period) begin
          check($sformatf("done_%02h", cur.data), 32'(seen), 32'(3'b101));
          $display("[TB] frame %02h completed, %0d clocks per bit", cur.data, cur.period);
          in_frame = 1'b0;
          gap      = 0;
        end else begin
          bit_i = j / cur.period;
          want  = {2'b01, frame_bit(cur.data, bit_i)};
          if (seen !== want) begin
            if (bad == 0) first_bad = seen;
            bad++;
          end
          if (j % cur.period == cur.period - 1) begin
            check($sformatf("frame_%02h_bit%0d", cur.data, bit_i),
                  32'((bad == 0) ? want : first_bad), 32'(want));
            bad = 0;
          end
        end
        j++;
      end
      mon_busy = in_frame;
    end
  end

  // ---------------- stimulus ----------------
  // Returns at the first negedge after acceptance (cycle 0 of the frame).
  task automatic send(input logic [7:0] d, input logic [2:0] b, input int cut, input bit b2b);
    bit got;
    got = 1'b0;
    if (b2b) begin
      for (int k = 0; k < 12000; k++) begin
        @(negedge clock);
        if (Tx_DONE === 1'b1) begin
          got = 1'b1;
          break;
        end
      end
      check("done_seen_for_b2b", 32'(got), 32'd1);
    end else begin
      @(negedge clock);
    end
    Tx_DATA     = d;
    baud_select = b;
    Tx_WR       = 1'b1;
    exp_q.push_back('{data: d, period: period_of(b), cut: cut, b2b: b2b});
    @(negedge clock);
    Tx_WR = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < max_cycles; k++) begin
      @(negedge clock);
      if (Tx_BUSY === 1'b0 && !mon_busy && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_reached", 32'(ok), 32'd1);
  endtask

  initial begin : stim
    int m;
    logic [2:0] sel;
    logic [7:0] d;
    reset       = 1'b1;
    baud_select = 3'b111;
    Tx_EN       = 1'b1;
    Tx_WR       = 1'b0;
    Tx_DATA     = 8'h00;
    repeat (3) @(negedge clock);
    check("reset_txd",  32'(TxD),     32'd1);
    check("reset_busy", 32'(Tx_BUSY), 32'd0);
    check("reset_done", 32'(Tx_DONE), 32'd0);
    reset = 1'b0;

    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      check($sformatf("divisor_sel%0d", s), baud_divisor(50_000_000, 16, sel), div_tab[s]);
    end

    // Single frame, 0x15 at 115200
    send(8'h15, 3'b111, 0, 1'b0);
    wait_idle(6000);

    // Back-to-back frames written in the done cycle
    send(8'h11, 3'b111, 0, 1'b0);
    send(8'hA5, 3'b111, 0, 1'b1);
    wait_idle(6000);

    // Write while busy is ignored
    send(8'h3C, 3'b111, 0, 1'b0);
    repeat (3 * 432) @(negedge clock);
    Tx_DATA = 8'hFF;
    Tx_WR   = 1'b1;
    @(negedge clock);
    Tx_WR   = 1'b0;
    wait_idle(6000);
    repeat (500) @(negedge clock);

    // Write while disabled is ignored
    Tx_EN   = 1'b0;
    Tx_DATA = 8'h5A;
    Tx_WR   = 1'b1;
    @(negedge clock);
    Tx_WR   = 1'b0;
    repeat (200) @(negedge clock);
    check("disabled_busy", 32'(Tx_BUSY), 32'd0);
    Tx_EN = 1'b1;
    repeat (10) @(negedge clock);

    // Enable dropped during data bit 4, then a clean frame
    m = 5 * 432 + 216;
    send(8'h96, 3'b111, m + 1, 1'b0);
    repeat (m) @(negedge clock);
    Tx_EN = 1'b0;
    @(negedge clock);
    Tx_EN = 1'b1;
    repeat (100) @(negedge clock);
    send(8'h96, 3'b111, 0, 1'b0);
    wait_idle(6000);

    // Rate change mid-frame has no effect (57600, 0x00)
    send(8'h00, 3'b110, 0, 1'b0);
    repeat (2 * 864) @(negedge clock);
    baud_select = 3'b111;
    wait_idle(12000);

    // Reset pulse during the parity bit, then a fresh frame
    m = 9 * 432 + 216;
    send(8'hC3, 3'b111, m + 1, 1'b0);
    repeat (m) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("reset_mid_busy", 32'(Tx_BUSY), 32'd0);
    send(8'h3A, 3'b111, 0, 1'b0);
    wait_idle(6000);

    // Random bytes, some back-to-back
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      if (i > 0 && $urandom_range(0, 1) == 1) begin
        send(d, 3'b111, 0, 1'b1);
      end else begin
        wait_idle(6000);
        repeat ($urandom_range(1, 50)) @(negedge clock);
        send(d, 3'b111, 0, 1'b0);
      end
    end
    wait_idle(6000);
    repeat (20) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
Serial transmitter that feeds the uart_receiver's RxD line. It takes an 8-bit byte over a single-cycle write strobe and serialises it as a frame: start bit, 8 data bits LSB first, even parity bit, stop bit. Bit timing comes from the same baud_select encoding and 16x sample-tick scheme as the receiver, so the two blocks loop back directly (TxD -> RxD).

Parameters:
CLK_HZ, 50_000_000, system clock frequency; the baud divisor table is derived from it.
OVERSAMPLE, 16, sample ticks per bit period.

Ports:
clock  input  1  system clock (50 MHz nominal).
reset  input  1  synchronous, active-high reset.
baud_select  input  3  rate select: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200.
Tx_EN  input  1  transmitter enable; 0 holds the block idle and aborts any frame in progress.
Tx_WR  input  1  single-cycle write strobe for Tx_DATA.
Tx_DATA  input  8  byte to send; sampled only on an accepted Tx_WR.
TxD  output  1  serial line; idles high.
Tx_BUSY  output  1  high from the cycle after acceptance until the frame completes.
Tx_DONE  output  1  one-cycle pulse when the stop bit finishes.

Behaviour:
- Reset: TxD=1, Tx_BUSY=0, Tx_DONE=0, FSM=IDLE, tick counter=0, bit counter=0.
- Divisor DIV = round(CLK_HZ/(OVERSAMPLE*baud)). At 50 MHz the values are 10417, 2604, 651, 326, 163, 81, 54, 27.
- Sample tick: one-cycle pulse when the divisor counter reaches DIV-1. The counter clears on reset, while Tx_EN=0, and on frame acceptance.
- Bit period: exactly OVERSAMPLE ticks, i.e. 16*DIV clocks. At 111 this is 432 clocks = 8640 ns.
- Frame acceptance: Tx_WR=1 while Tx_EN=1 and Tx_BUSY=0, in IDLE or in the Tx_DONE cycle. On acceptance:
  - Tx_DATA and baud_select are latched.
  - TxD goes low and Tx_BUSY goes high on the next clock edge (latency 1 cycle).
- baud_select changes mid-frame have no effect until the next accepted write.
- FSM states and transitions:
  - IDLE -> START on acceptance.
  - START (TxD=0) -> DATA after 16 ticks.
  - DATA (TxD=shift[0]) sends bits 0..7, 16 ticks each; the 3-bit counter wraps 7 -> exit to PARITY.
  - PARITY (TxD = XOR of latched data) -> STOP after 16 ticks.
  - STOP (TxD=1) -> IDLE after 16 ticks.
- Completion: on leaving STOP, Tx_DONE=1 and Tx_BUSY=0 for that cycle. A Tx_WR in that same cycle is accepted, giving back-to-back frames with no idle gap.
- Whole frame: 11 bit periods = 176*DIV clocks.
- Tx_WR while Tx_BUSY=1: ignored, with no effect on the frame or the latched data.
- Tx_WR while Tx_EN=0: ignored.
- Tx_EN falling mid-frame: next cycle FSM=IDLE, TxD=1, Tx_BUSY=0, and no Tx_DONE pulse.
- Reset mid-frame: same as the reset values above. The partial frame is abandoned, and the receiver sees a truncated frame as a framing error.

Decomposition:
- uart_pkg holds:
  - the baud_select encoding constants;
  - the divisor lookup function of CLK_HZ and OVERSAMPLE;
  - the tx FSM state typedef (IDLE, START, DATA, PARITY, STOP);
  - the frame-length constants (8 data bits, 16 ticks per bit).
- Sub-module baud_controller: inputs clock, reset, clear, baud_select; output sample_tick. The receiver uses the same module unchanged.

Test Plan:
- Tx_DATA=0x15, baud 111, single Tx_WR -> TxD shows 0,1,0,1,0,1,0,0,0,1,1, each level held 432 clocks. Tx_BUSY is high for 4752 clocks, then a one-cycle Tx_DONE pulse.
- Loopback TxD->uart_receiver RxD: send 0x11 then 0xA5 back-to-back, with the second Tx_WR in the Tx_DONE cycle -> receiver shows Rx_VALID with Rx_DATA=0x11, then 0xA5, and Rx_PERROR=0, Rx_FERROR=0. There is no idle-high gap between the two frames.
- Tx_WR with 0xFF issued mid-frame while sending 0x3C -> the 0x3C frame is unchanged and 0xFF is never transmitted.
- Tx_EN dropped during data bit 4 -> TxD=1 and Tx_BUSY=0 one cycle later, with no Tx_DONE. A subsequent write after re-enable sends a clean full frame.
- baud 000, data 0x00 -> start bit lasts 166672 clocks and the parity bit is 0. Switching baud_select to 111 mid-frame leaves every bit at 166672 clocks.
- reset pulsed for 1 cycle mid-parity-bit -> next cycle TxD=1, Tx_BUSY=0, Tx_DONE=0, and the next write starts from the START state.
